// File: rtl/xor_bist_ctrl.sv
// Exhaustive self-test sequencer for an odd-parity gate: sweeps all 2^WIDTH vectors, checks z after a settle delay.
// Optional XOR_BIST_STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module xor_bist_ctrl #(
  parameter int WIDTH         = 3,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] vec_out,
  input  logic             z,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [WIDTH:0]   err_cnt,
  output logic [WIDTH-1:0] fail_vec
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPLY,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  localparam logic [WIDTH:0]   ERR_ONE = 1;
  localparam logic [WIDTH-1:0] VEC_ONE = 1;
  localparam logic [7:0]       SETTLE_LD = 8'(SETTLE_CYCLES);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic [WIDTH-1:0] fail_q, fail_d;
  logic [WIDTH:0]   err_q, err_d;
  logic             pass_q, pass_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             expected;
  logic             mismatch;

  // An X or Z on the gate output must be treated as a failure, hence the case inequality.
  assign expected = ^vec_q;
  assign mismatch = (z !== expected);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    fail_d  = fail_q;
    err_d   = err_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          vec_d   = '0;
          err_d   = '0;
          fail_d  = '0;
          pass_d  = 1'b0;
          state_d = S_APPLY;
        end
      end
      S_APPLY: begin
        busy = 1'b1;
        if (SETTLE_LD == 8'd0) begin
          state_d = S_CHECK;
        end else begin
          cnt_d   = SETTLE_LD;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        busy  = 1'b1;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q <= 8'd1) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        busy = 1'b1;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
        if (mismatch) begin
          fail_d  = vec_q;
          err_d   = ERR_ONE;
          pass_d  = 1'b0;
          state_d = S_DONE;
        end else if (&vec_q) begin
          pass_d  = (err_q == '0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          state_d = S_APPLY;
        end
`else
        if (mismatch) begin
          err_d = err_q + ERR_ONE;
          if (err_q == '0) begin
            fail_d = vec_q;
          end
        end
        // pass is published on DONE entry so it is already valid during the done pulse.
        if (&vec_q) begin
          pass_d  = (err_d == '0);
          state_d = S_DONE;
        end else begin
          vec_d   = vec_q + VEC_ONE;
          state_d = S_APPLY;
        end
`endif
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      fail_q  <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
    end
  end

  assign vec_out  = vec_q;
  assign err_cnt  = err_q;
  assign fail_vec = fail_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_xor_bist_ctrl.sv
// Directed bench for xor_bist_ctrl: gate models drive z, run expectations are queued at start and popped at done.
module tb_xor_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start0 = 1'b0;
  logic [2:0] vec, vec0, fvec, fvec0;
  logic [3:0] err, err0;
  logic       z, z0, busy, busy0, done, done0, pass, pass0;

  int         mode = 0;
  logic       dly = 1'b0;
  logic       d1, d2;
  int         sel = 0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  xor_bist_ctrl #(.WIDTH(3), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_out(vec), .z(z), .busy(busy),
    .done(done), .pass(pass), .err_cnt(err), .fail_vec(fvec)
  );

  xor_bist_ctrl #(.WIDTH(3), .SETTLE_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .vec_out(vec0), .z(z0), .busy(busy0),
    .done(done0), .pass(pass0), .err_cnt(err0), .fail_vec(fvec0)
  );

  // Gate models for the default instance: 0 good XOR, 1 stuck at 0, 2 XNOR.
  always_comb begin
    case (mode)
      1:       z = 1'b0;
      2:       z = ~^vec;
      default: z = ^vec;
    endcase
  end

  // Slow gate for the zero-settle instance: output lags the inputs by two register stages.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= ^vec0;
      d2 <= d1;
    end
  end
  assign z0 = dly ? d2 : ^vec0;

  logic [2:0] o_vec, o_fvec;
  logic [3:0] o_err;
  logic       o_busy, o_done, o_pass;
  always_comb begin
    o_vec  = (sel == 1) ? vec0  : vec;
    o_fvec = (sel == 1) ? fvec0 : fvec;
    o_err  = (sel == 1) ? err0  : err;
    o_busy = (sel == 1) ? busy0 : busy;
    o_done = (sel == 1) ? done0 : done;
    o_pass = (sel == 1) ? pass0 : pass;
  end

  typedef struct {
    int         edge_n;
    logic       pass;
    logic [3:0] err;
    logic [2:0] fvec;
    logic [2:0] vec;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int e, input logic p, input logic [3:0] ec,
                          input logic [2:0] fv, input logic [2:0] v);
    exp_t x;
    x.edge_n = e; x.pass = p; x.err = ec; x.fvec = fv; x.vec = v;
    sb.push_back(x);
  endtask

  task automatic drive_start(input logic v);
    if (sel == 1) start0 = v;
    else          start  = v;
  endtask

  // Starts a run on the selected instance; restart_edge > 0 re-asserts start for one
  // cycle so that it is sampled at that edge while the run is in progress.
  task automatic run(input string tag, input int restart_edge);
    int         edges;
    int         done_edge;
    int         extra_done;
    bit         got;
    bit         seq_bad;
    logic [2:0] prev;
    logic [2:0] d_vec, d_fvec;
    logic [3:0] d_err;
    logic       d_pass, d_busy;
    exp_t       e;
    got = 0; seq_bad = 0; extra_done = 0; done_edge = -1;
    d_vec = '0; d_fvec = '0; d_err = '0; d_pass = 1'b0; d_busy = 1'b0;
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    edges = 0;
    @(negedge clk);
    drive_start(1'b0);
    check({tag, "_vec_start"}, o_vec, 3'd0);
    check({tag, "_busy_start"}, o_busy, 1'b1);
    prev = o_vec;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      drive_start(restart_edge > 0 && edges + 1 == restart_edge);
      if (o_vec !== prev && o_vec !== 3'(prev + 3'd1)) seq_bad = 1;
      prev = o_vec;
      if (o_done === 1'b1) begin
        got = 1; done_edge = edges;
        d_vec = o_vec; d_fvec = o_fvec; d_err = o_err; d_pass = o_pass; d_busy = o_busy;
      end
    end
    drive_start(1'b0);
    if (!got) begin
      check({tag, "_done_timeout"}, 0, 1);
      return;
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_done === 1'b1) extra_done++;
    end
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, "_done_edge"}, done_edge, e.edge_n);
    check({tag, "_pass"}, d_pass, e.pass);
    check({tag, "_err_cnt"}, d_err, e.err);
    check({tag, "_vec_final"}, d_vec, e.vec);
    if (!e.pass) check({tag, "_fail_vec"}, d_fvec, e.fvec);
    check({tag, "_busy_at_done"}, d_busy, 1'b0);
    check({tag, "_vec_sequence"}, seq_bad, 1'b0);
    check({tag, "_extra_done"}, extra_done, 0);
    check({tag, "_pass_hold"}, o_pass, e.pass);
    check({tag, "_err_hold"}, o_err, e.err);
    check({tag, "_vec_hold"}, o_vec, e.vec);
    check({tag, "_busy_after"}, o_busy, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_vec"}, vec, 3'd0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_err"}, err, 4'd0);
    check({tag, "_fvec"}, fvec, 3'd0);
    check({tag, "_vec0"}, vec0, 3'd0);
    check({tag, "_busy0"}, busy0, 1'b0);
    check({tag, "_err0"}, err0, 4'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   aborted_done;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    // Zero settle with a two-stage gate: vector k is judged against parity(k-1) (parity(0) for k=0).
    sel = 1; dly = 1'b1;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    push_exp(4, 1'b0, 4'd1, 3'd1, 3'd1);
`else
    push_exp(16, 1'b0, 4'd5, 3'd1, 3'd7);
`endif
    run("slow_gate", 0);

    dly = 1'b0;
    push_exp(16, 1'b1, 4'd0, 3'd0, 3'd7);
    run("settle0_good", 0);

    sel = 0; mode = 0;
    push_exp(32, 1'b1, 4'd0, 3'd0, 3'd7);
    run("good", 0);

    mode = 1;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    push_exp(8, 1'b0, 4'd1, 3'd1, 3'd1);
`else
    push_exp(32, 1'b0, 4'd4, 3'd1, 3'd7);
`endif
    run("stuck0", 0);

    mode = 2;
`ifdef XOR_BIST_STOP_ON_FAIL_EN
    push_exp(4, 1'b0, 4'd1, 3'd0, 3'd0);
`else
    push_exp(32, 1'b0, 4'd8, 3'd0, 3'd7);
`endif
    run("xnor", 0);

    mode = 0;
    push_exp(32, 1'b1, 4'd0, 3'd0, 3'd7);
    run("restart_ignored", 10);

    // Reset in the middle of a run, once vector 4 is applied.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec !== 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_vec4", vec, 3'd4);
    rst = 1'b1;
    #1;
    check_zero("abort_reset");
    @(negedge clk);
    rst = 1'b0;
    aborted_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) aborted_done++;
    end
    check("abort_no_done", aborted_done, 0);
    check("abort_idle_busy", busy, 1'b0);

    push_exp(32, 1'b1, 4'd0, 3'd0, 3'd7);
    run("after_abort", 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
